// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog timer.
//   wdt_state_e      : watchdog FSM state type (IDLE, RUN, WARN, BITE)
//   CNT_W_DEFAULT    : default width of the cycle counter and thresholds
//   KICK_KEY_DEFAULT : default key a kick must carry to be accepted
package watchdog_pkg;

  localparam int unsigned CNT_W_DEFAULT    = 32;
  localparam logic [15:0] KICK_KEY_DEFAULT = 16'hA5C3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WARN = 2'd2,
    ST_BITE = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/watchdog_timer.sv
// Keyed watchdog timer with a pre-timeout warning stage.
//   clk_i         : clock, rising edge
//   rst_i         : asynchronous active-high reset
//   enable_i      : arm (1) / disarm (0)
//   timeout_i     : cycles allowed between kicks, latched when arming
//   warn_i        : warning threshold, latched when arming
//   kick_valid_i  : kick request; kick_key_i carries its key
//   kick_ready_o  : kick accepted when valid and ready (RUN/WARN only)
//   clear_i       : acknowledge a bite, return to IDLE
//   count_o       : cycles since arm or last accepted kick
//   warn_o        : high while in WARN
//   bite_o        : high while in BITE
//   bad_kick_o    : one-cycle pulse after a wrong-key handshake
//   bite_cnt_o    : number of bites since reset, saturating at 255
module watchdog_timer
  import watchdog_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEFAULT,
  parameter logic [15:0] KICK_KEY = KICK_KEY_DEFAULT,
  parameter bit          STRICT   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic [CNT_W-1:0] warn_i,
  input  logic             kick_valid_i,
  input  logic [15:0]      kick_key_i,
  output logic             kick_ready_o,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             warn_o,
  output logic             bite_o,
  output logic             bad_kick_o,
  output logic [7:0]       bite_cnt_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  wdt_state_e       state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] timeout_q, warn_q;
  logic             load;
  logic             handshake, key_ok, good_kick, bad_kick;
  logic             warn_en;

  assign kick_ready_o = (state == ST_RUN) || (state == ST_WARN);
  assign handshake    = kick_valid_i && kick_ready_o;
  assign key_ok       = (kick_key_i == KICK_KEY);
  assign good_kick    = handshake && key_ok;
  assign bad_kick     = handshake && !key_ok;
  // WARN only exists when the warning threshold lies strictly inside the timeout.
  assign warn_en      = (warn_q != '0) && (warn_q < timeout_q);
  assign count_o      = count;

  always_comb begin
    state_n = state;
    count_n = count;
    load    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        count_n = '0;
        if (enable_i && (timeout_i != '0)) begin
          state_n = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN, ST_WARN: begin
        // Priority: disarm, good kick, strict bad kick, timeout, normal count.
        if (!enable_i) begin
          state_n = ST_IDLE;
          count_n = '0;
        end else if (good_kick) begin
          state_n = ST_RUN;
          count_n = '0;
        end else if (STRICT && bad_kick) begin
          state_n = ST_BITE;
        end else if (count == timeout_q - ONE) begin
          // Count holds at timeout-1 so it never exceeds the threshold.
          state_n = ST_BITE;
        end else begin
          count_n = count + ONE;
          if ((state == ST_RUN) && warn_en && (count == warn_q - ONE)) begin
            state_n = ST_WARN;
          end
        end
      end
      ST_BITE: begin
        if (clear_i) begin
          state_n = ST_IDLE;
          count_n = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      count      <= '0;
      timeout_q  <= '0;
      warn_q     <= '0;
      warn_o     <= 1'b0;
      bite_o     <= 1'b0;
      bad_kick_o <= 1'b0;
      bite_cnt_o <= '0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      if (load) begin
        timeout_q <= timeout_i;
        warn_q    <= warn_i;
      end
      warn_o     <= (state_n == ST_WARN);
      bite_o     <= (state_n == ST_BITE);
      bad_kick_o <= bad_kick;
      if ((state_n == ST_BITE) && (state != ST_BITE) && (bite_cnt_o != '1)) begin
        bite_cnt_o <= bite_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_watchdog_timer.sv
// Testbench for watchdog_timer: a lenient (STRICT=0, 32-bit) and a strict
// (STRICT=1, 16-bit) instance share stimulus; each is compared every cycle
// against a behavioural model plus directed scenario checks.
module tb_watchdog_timer;

  localparam logic [15:0] KEY = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst, enable, kick_valid, clear;
  logic [31:0] timeout, warn;
  logic [15:0] kick_key;

  logic        kr0, warn0, bite0, bad0;
  logic [31:0] count0;
  logic [7:0]  bites0;
  logic        kr1, warn1, bite1, bad1;
  logic [15:0] count1;
  logic [7:0]  bites1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  watchdog_timer #(.CNT_W(32), .KICK_KEY(KEY), .STRICT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .timeout_i(timeout), .warn_i(warn),
    .kick_valid_i(kick_valid), .kick_key_i(kick_key), .kick_ready_o(kr0), .clear_i(clear),
    .count_o(count0), .warn_o(warn0), .bite_o(bite0), .bad_kick_o(bad0), .bite_cnt_o(bites0)
  );

  watchdog_timer #(.CNT_W(16), .KICK_KEY(KEY), .STRICT(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .timeout_i(timeout[15:0]), .warn_i(warn[15:0]),
    .kick_valid_i(kick_valid), .kick_key_i(kick_key), .kick_ready_o(kr1), .clear_i(clear),
    .count_o(count1), .warn_o(warn1), .bite_o(bite1), .bad_kick_o(bad1), .bite_cnt_o(bites1)
  );

  // Reference model: "armed" / "bitten" flags plus a cycle count; the warning
  // phase is derived from where the count sits relative to the thresholds.
  bit          m_armed  [2];
  bit          m_bitten [2];
  bit          m_bad    [2];
  int unsigned m_cnt    [2];
  int unsigned m_to     [2];
  int unsigned m_wr     [2];
  int unsigned m_bites  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_bitten[i] = 0; m_bad[i] = 0;
      m_cnt[i] = 0; m_to[i] = 0; m_wr[i] = 0; m_bites[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit          ready, hs, good, strict;
      int unsigned to_in, wr_in;
      strict = (i == 1);
      ready  = m_armed[i] && !m_bitten[i];
      hs     = kick_valid && ready;
      good   = hs && (kick_key == KEY);
      to_in  = (i == 1) ? int'(timeout[15:0]) : timeout;
      wr_in  = (i == 1) ? int'(warn[15:0])    : warn;
      m_bad[i] = hs && !good;
      if (!m_armed[i]) begin
        m_cnt[i] = 0;
        if (enable && to_in != 0) begin
          m_armed[i] = 1; m_to[i] = to_in; m_wr[i] = wr_in;
        end
      end else if (m_bitten[i]) begin
        if (clear) begin m_armed[i] = 0; m_bitten[i] = 0; m_cnt[i] = 0; end
      end else if (!enable) begin
        m_armed[i] = 0; m_cnt[i] = 0;
      end else if (good) begin
        m_cnt[i] = 0;
      end else if ((strict && m_bad[i]) || (m_cnt[i] + 1 == m_to[i])) begin
        m_bitten[i] = 1;
        if (m_bites[i] < 255) m_bites[i]++;
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic kr, input logic w, input logic b,
                           input logic bad, input logic [31:0] cnt, input logic [7:0] bc);
    bit exp_warn;
    exp_warn = m_armed[i] && !m_bitten[i] && m_wr[i] > 0 && m_wr[i] < m_to[i] && m_cnt[i] >= m_wr[i];
    check($sformatf("d%0d.kick_ready", i), 64'(kr),  64'(m_armed[i] && !m_bitten[i]));
    check($sformatf("d%0d.warn", i),       64'(w),   64'(exp_warn));
    check($sformatf("d%0d.bite", i),       64'(b),   64'(m_bitten[i]));
    check($sformatf("d%0d.bad_kick", i),   64'(bad), 64'(m_bad[i]));
    check($sformatf("d%0d.count", i),      64'(cnt), 64'(m_cnt[i]));
    check($sformatf("d%0d.bite_cnt", i),   64'(bc),  64'(m_bites[i]));
  endtask

  task automatic compare_all();
    check_dut(0, kr0, warn0, bite0, bad0, count0, bites0);
    check_dut(1, kr1, warn1, bite1, bad1, {16'h0, count1}, bites1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
  endtask

  int          warn_rise, bite_rise, warn_pulses;
  logic [31:0] max_cnt;
  logic        prev_warn;

  initial begin
    rst = 1'b1; enable = 1'b0; timeout = '0; warn = '0;
    kick_valid = 1'b0; kick_key = '0; clear = 1'b0;
    model_reset();
    #12;
    compare_all();
    check("reset.count0", 64'(count0), 64'd0);
    check("reset.bites1", 64'(bites1), 64'd0);
    rst = 1'b0;
    tick();

    // Unkicked timeout: warn at cycle 6, bite at cycle 10.
    enable = 1'b1; timeout = 10; warn = 6;
    tick();
    warn_rise = -1; bite_rise = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (warn0 && warn_rise < 0) warn_rise = k;
      if (bite0 && bite_rise < 0) bite_rise = k;
    end
    check("timeout.warn_cycle", 64'(warn_rise), 64'd6);
    check("timeout.bite_cycle", 64'(bite_rise), 64'd10);
    check("timeout.bite_cnt",   64'(bites0),    64'd1);
    check("timeout.count_hold", 64'(count0),    64'd9);
    enable = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();

    // Kicked every 8 cycles for 100 cycles.
    enable = 1'b1;
    tick();
    max_cnt = 0; warn_pulses = 0; prev_warn = 1'b0;
    for (int k = 0; k < 100; k++) begin
      kick_valid = (m_cnt[0] == 7);
      kick_key   = KEY;
      tick();
      if (count0 > max_cnt) max_cnt = count0;
      if (warn0 && !prev_warn) warn_pulses++;
      prev_warn = warn0;
    end
    kick_valid = 1'b0;
    check("kicked.max_count",   64'(max_cnt),     64'd7);
    check("kicked.warn_pulses", 64'(warn_pulses), 64'd12);
    check("kicked.no_bite",     64'(bite0),       64'd0);

    // Wrong-key kick at count 3.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    repeat (3) tick();
    kick_valid = 1'b1; kick_key = 16'h0000;
    tick();
    kick_valid = 1'b0;
    check("badkick.lenient_count", 64'(count0), 64'd4);
    check("badkick.lenient_pulse", 64'(bad0),   64'd1);
    check("badkick.strict_bite",   64'(bite1),  64'd1);
    tick();
    check("badkick.pulse_once", 64'(bad0),   64'd0);
    check("badkick.continues",  64'(count0), 64'd5);

    // Kick at the last possible cycle, then disable racing a kick.
    enable = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    repeat (9) tick();
    check("lastkick.count9", 64'(count0), 64'd9);
    kick_valid = 1'b1; kick_key = KEY;
    tick();
    kick_valid = 1'b0;
    check("lastkick.count0", 64'(count0), 64'd0);
    check("lastkick.no_bite", 64'(bite1), 64'd0);
    repeat (2) tick();
    enable = 1'b0; kick_valid = 1'b1; kick_key = KEY;
    tick();
    kick_valid = 1'b0;
    check("disable.idle", 64'(kr0), 64'd0);

    // Asynchronous reset mid-RUN at count 5.
    enable = 1'b1;
    tick();
    repeat (5) tick();
    check("asyncrst.pre", 64'(count0), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("asyncrst.count0", 64'(count0), 64'd0);
    check("asyncrst.count1", 64'(count1), 64'd0);
    model_reset();
    compare_all();
    rst = 1'b0;
    tick();

    // Drive well over 256 bites to reach saturation.
    timeout = 1; warn = 0;
    for (int k = 0; k < 800; k++) begin
      clear = m_bitten[0];
      tick();
    end
    clear = 1'b0;
    check("saturate.bites0", 64'(bites0), 64'd255);
    check("saturate.bites1", 64'(bites1), 64'd255);

    // Randomized traffic.
    enable = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom % 200) == 0;
      enable     = ($urandom % 16) != 0;
      timeout    = $urandom_range(0, 15);
      warn       = $urandom_range(0, 15);
      kick_valid = ($urandom % 5) == 0;
      kick_key   = (($urandom % 10) < 7) ? KEY : 16'($urandom);
      clear      = ($urandom % 8) == 0;
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/watchdog_timer.md
WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 Parameter CNT_W, default 32, width of the cycle counter and thresholds.
REQ-002 Parameter KICK_KEY, default 16'hA5C3, key value a kick must carry to be accepted.
REQ-003 Parameter STRICT, default 0; 1 = a bad-key kick forces an immediate bite.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 enable_i  input  1  arm (1) or disarm (0) the watchdog.
REQ-007 timeout_i  input  CNT_W  cycles allowed between kicks; latched at arm.
REQ-008 warn_i  input  CNT_W  pre-timeout warning threshold; latched at arm.
REQ-009 kick_valid_i  input  1  kick request.
REQ-010 kick_key_i  input  16  key qualifying the kick.
REQ-011 kick_ready_o  output  1  kick accepted this cycle when valid and ready.
REQ-012 clear_i  input  1  acknowledge a bite and return to IDLE.
REQ-013 count_o  output  CNT_W  cycles since arm or last accepted kick.
REQ-014 warn_o  output  1  high while in WARN.
REQ-015 bite_o  output  1  high while in BITE.
REQ-016 bad_kick_o  output  1  one-cycle pulse, cycle after a wrong-key handshake.
REQ-017 bite_cnt_o  output  8  bites since reset, saturating at 255.

Function
REQ-018 States: IDLE, RUN, WARN, BITE.
REQ-019 IDLE: count_o=0; enable_i=1 and timeout_i!=0 -> RUN next cycle, latching timeout_i and warn_i; enable_i=1 with timeout_i=0 -> stay in IDLE.
REQ-020 kick_ready_o=1 in RUN and WARN, 0 in IDLE and BITE; a handshake is kick_valid_i & kick_ready_o.
REQ-021 Good kick: handshake with kick_key_i==KICK_KEY -> count_o=0 next cycle and state RUN (from WARN or RUN).
REQ-022 Bad kick: handshake with wrong key -> bad_kick_o=1 next cycle only.
REQ-023 Bad kick with STRICT=0 -> no effect on count_o; with STRICT=1 -> BITE next cycle.
REQ-024 RUN/WARN without good kick: count_o increments by 1 per cycle.
REQ-025 RUN -> WARN when count_o==warn_q-1, for 0<warn_q<timeout_q only; otherwise WARN is never entered.
REQ-026 RUN/WARN -> BITE when count_o==timeout_q-1 without good kick; count_o holds in BITE.
REQ-027 A good kick in the same cycle as a warn or bite condition wins: no transition, count_o=0.
REQ-028 timeout_q=1: BITE one cycle after entering RUN unless kicked in that first cycle.
REQ-029 enable_i=0 in RUN/WARN -> IDLE next cycle, count_o=0; it has priority over a kick.
REQ-030 BITE ignores enable_i and kicks; clear_i=1 -> IDLE next cycle.
REQ-031 bite_cnt_o increments once on each entry to BITE, saturating at 255.
REQ-032 The counter never wraps: the BITE transition fires before count_o can exceed timeout_q-1.
REQ-033 All outputs are registered except kick_ready_o, which decodes from state.

Reset
REQ-034 rst_i=1 asynchronously forces IDLE: count_o=0, warn_o=0, bite_o=0, bad_kick_o=0, bite_cnt_o=0, and the latched thresholds to 0.
REQ-035 Reset mid-RUN or mid-BITE discards all progress; re-arming requires enable_i=1 after rst_i falls.

Structure
REQ-036 Package watchdog_pkg holds the state enum type, the default CNT_W and the default KICK_KEY.
REQ-037 Single module, no sub-module; the FSM and counter sit in one always_ff block with a separate next-state always_comb block.

Verification
REQ-038 Arm with timeout_i=10, warn_i=6, no kicks -> warn_o rises at cycle 6, bite_o rises at cycle 10, bite_cnt_o=1.
REQ-039 Arm with timeout_i=10 and a good kick every 8 cycles for 100 cycles -> bite_o stays 0, count_o never exceeds 7, warn_o pulses each period.
REQ-040 STRICT=0, kick with key 16'h0000 at count 3 -> bad_kick_o pulses once and count_o continues to 4; STRICT=1 -> bite_o=1 next cycle.
REQ-041 Good kick exactly at count_o=9 with timeout_i=10 -> no bite, count_o=0; enable_i=0 and a kick in the same cycle -> IDLE.
REQ-042 In BITE assert clear_i -> IDLE; pulse rst_i mid-RUN at count 5 -> count_o=0 immediately with no clock edge; force 256 bites -> bite_cnt_o=255.
